// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter (LSL/LSR/ASR/ROR/RRX) that moves at most STEP bits per cycle.
// result/carry_out are loaded only when an operation completes and hold until the next one finishes.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   src,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         sh_type,
  input  logic               carry_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out
);

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   val;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         typ;

  logic [31:0]        amt;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]   tmp;
  logic               stc;

  // One step: shift the working value by min(rem, STEP); stc is the last bit
  // shifted out, which matches the single-shot carry on the final step.
  always_comb begin
    amt = (32'(rem) > 32'(STEP)) ? 32'(STEP) : 32'(rem);
    nxt = val;
    tmp = '0;
    stc = 1'b0;
    case (typ)
      LSL: begin
        nxt = val << amt;
        tmp = val << (amt - 32'd1);
        stc = tmp[WIDTH-1];
      end
      LSR: begin
        nxt = val >> amt;
        tmp = val >> (amt - 32'd1);
        stc = tmp[0];
      end
      ASR: begin
        nxt = $signed(val) >>> amt;
        tmp = val >> (amt - 32'd1);
        stc = tmp[0];
      end
      default: begin
        nxt = (val >> amt) | (val << (32'(WIDTH) - amt));
        stc = nxt[WIDTH-1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      val       <= '0;
      rem       <= '0;
      typ       <= LSL;
    end else begin
      case (state)
        SHIFT: begin
          val <= nxt;
          rem <= rem - amt[SHAMT_W-1:0];
          if (32'(rem) == amt) begin
            result    <= nxt;
            carry_out <= stc;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise
          done <= 1'b0;
          state <= IDLE;
          if (start) begin
            val <= src;
            rem <= shamt;
            typ <= sh_type;
            if (shamt == '0) begin
              if (sh_type == ROR) begin
                result    <= {carry_in, src[WIDTH-1:1]};
                carry_out <= src[0];
              end else begin
                result    <= src;
                carry_out <= carry_in;
              end
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=32, STEP=8): vector table plus hand-written
// sequences for mid-operation start, reset abort, reset priority and back-to-back ops.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src;
  logic [4:0]  shamt;
  logic [1:0]  sh_type;
  logic        carry_in;
  logic        busy, done, carry_out;
  logic [31:0] result;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  seq_shifter #(.WIDTH(32), .STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .shamt(shamt),
    .sh_type(sh_type), .carry_in(carry_in), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] src;
    logic [4:0]  sh;
    logic        cin;
    logic [31:0] exp_res;
    logic        exp_cy;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Count negedges after E0 until done is seen; -1 on timeout.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] s, input logic [4:0] a, input logic c);
    sh_type = t; src = s; shamt = a; carry_in = c; start = 1'b1;
  endtask

  vec_t vecs[12];
  int lat;
  int extra;

  initial begin
    vecs[0]  = '{2'b00, 32'h000000F1, 5'd4,  1'b0, 32'h00000F10, 1'b0, 1};
    vecs[1]  = '{2'b10, 32'h80000010, 5'd20, 1'b0, 32'hFFFFF800, 1'b0, 3};
    vecs[2]  = '{2'b11, 32'h00000001, 5'd1,  1'b0, 32'h80000000, 1'b1, 1};
    vecs[3]  = '{2'b11, 32'h00000003, 5'd0,  1'b1, 32'h80000001, 1'b1, 0};
    vecs[4]  = '{2'b01, 32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001, 1'b1, 4};
    vecs[5]  = '{2'b00, 32'h80000001, 5'd1,  1'b0, 32'h00000002, 1'b1, 1};
    vecs[6]  = '{2'b00, 32'h12345678, 5'd0,  1'b1, 32'h12345678, 1'b1, 0};
    vecs[7]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 1'b0, 32'h00000000, 1'b1, 4};
    vecs[8]  = '{2'b11, 32'h12345678, 5'd12, 1'b0, 32'h67812345, 1'b0, 2};
    vecs[9]  = '{2'b00, 32'h00010000, 5'd16, 1'b0, 32'h00000000, 1'b1, 2};
    vecs[10] = '{2'b10, 32'h80000000, 5'd9,  1'b1, 32'hFFC00000, 1'b0, 2};
    vecs[11] = '{2'b11, 32'h00000002, 5'd0,  1'b0, 32'h00000001, 1'b0, 0};

    rst_n = 1'b0; start = 1'b0; src = '0; shamt = '0; sh_type = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].typ, vecs[i].src, vecs[i].sh, vecs[i].cin);
      @(negedge clk);
      start = 1'b0;
      src = ~vecs[i].src; shamt = 5'd7; carry_in = ~vecs[i].cin;
      wait_done(0, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d_carry", i), 32'(carry_out), 32'(vecs[i].exp_cy));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold", i), result, vecs[i].exp_res);
    end

    // start pulsed at E0+2 while shifting is ignored
    drive(2'b01, 32'hFFFFFFFF, 5'd31, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); drive(2'b00, 32'h0, 5'd1, 1'b1);
    @(negedge clk); start = 1'b0;
    wait_done(2, lat);
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_result", result, 32'h00000001);
    chk("ign_carry", 32'(carry_out), 32'd1);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("ign_no_extra", 32'(extra), 32'd0);

    // reset at E0+2 aborts the operation
    drive(2'b01, 32'hFFFFFFFF, 5'd31, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);

    // reset wins over simultaneous start
    rst_n = 1'b0;
    drive(2'b00, 32'h1, 5'd0, 1'b1);
    @(negedge clk);
    chk("prio_done", 32'(done), 32'd0);
    chk("prio_result", result, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("prio_idle", 32'(done | busy), 32'd0);

    // start held through DONE: back-to-back accept in the done cycle
    drive(2'b00, 32'h000000F1, 5'd4, 1'b0);
    @(negedge clk);
    wait_done(0, lat);
    chk("b2b_lat_a", 32'(lat), 32'd1);
    chk("b2b_result_a", result, 32'h00000F10);
    drive(2'b10, 32'h80000010, 5'd20, 1'b0);
    @(negedge clk); start = 1'b0;
    chk("b2b_busy_b", 32'(busy), 32'd1);
    wait_done(0, lat);
    chk("b2b_lat_b", 32'(lat), 32'd3);
    chk("b2b_result_b", result, 32'hFFFFF800);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STEP, default 8, maximum bits shifted per cycle; power of two, 1..WIDTH.
REQ-003 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request; accepted when sampled high in IDLE or DONE.
REQ-007 SHALL have port src  input  WIDTH  operand to shift.
REQ-008 SHALL have port shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port sh_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port carry_in  input  1  carry flag used for zero-amount shifts and RRX.
REQ-011 SHALL have port busy  output  1  high while in SHIFT.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result and carry_out valid.
REQ-013 SHALL have port result  output  WIDTH  shifted value, held until the next accept.
REQ-014 SHALL have port carry_out  output  1  last bit shifted out, held with result.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE; done=1 only in DONE, busy=1 only in SHIFT.
REQ-016 On accept edge E0, SHALL capture src, shamt, sh_type and carry_in into internal registers; later input changes have no effect on the operation.
REQ-017 If the captured shamt is 0, SHALL go from E0 directly to DONE; otherwise SHALL go to SHIFT.
REQ-018 Each SHIFT edge SHALL shift by min(remaining, STEP) and decrement remaining by the same amount; it SHALL enter DONE on the edge where remaining reaches 0.
REQ-019 done SHALL assert in the cycle following edge E0+ceil(shamt/STEP); the pulse SHALL last exactly one cycle.
REQ-020 LSL/LSR SHALL zero-fill, ASR SHALL replicate src[WIDTH-1], and ROR SHALL rotate right; the final value SHALL equal the single-shot shift by shamt.
REQ-021 carry_out for nonzero shamt SHALL be as follows: LSL src[WIDTH-shamt]; LSR/ASR src[shamt-1]; ROR result[WIDTH-1].
REQ-022 For shamt=0 with LSL/LSR/ASR, result SHALL be src and carry_out SHALL be the captured carry_in.
REQ-023 For shamt=0 with ROR (RRX), result SHALL be {carry_in, src[WIDTH-1:1]} and carry_out SHALL be src[0].
REQ-024 start in SHIFT SHALL be ignored, with no queuing.
REQ-025 start in DONE SHALL be accepted (back-to-back); that edge is E0 of the new operation.
REQ-026 Without start, DONE SHALL return to IDLE; result and carry_out SHALL hold their values.
REQ-027 shamt values >= WIDTH (non-power-of-two WIDTH) are out of contract; the module SHALL still terminate within ceil((2^SHAMT_W-1)/STEP) shift edges.

Reset
REQ-028 rst_n low at a rising edge SHALL force IDLE, busy=0, done=0, result=0, carry_out=0, and clear remaining.
REQ-029 Reset during SHIFT SHALL abort the operation; no done SHALL follow for it.
REQ-030 Reset SHALL take priority over a simultaneous start.

Verification (WIDTH=32, STEP=8)
REQ-031 LSL src=0x000000F1, shamt=4 -> result 0x00000F10, carry_out 0, done after E0+1.
REQ-032 ASR src=0x80000010, shamt=20 -> result 0xFFFFF800, carry_out 0, busy for 3 cycles, done after E0+3.
REQ-033 ROR src=0x00000001, shamt=1 -> 0x80000000, carry_out 1; RRX src=0x00000003, shamt=0, carry_in=1 -> 0x80000001, carry_out 1, done after E0.
REQ-034 LSR src=0xFFFFFFFF, shamt=31 -> result 0x00000001, carry_out 1, done after E0+4; a start pulsed at E0+2 is ignored.
REQ-035 LSR shamt=31 with rst_n low at E0+2 -> busy 0, done never pulses, result 0x00000000.
REQ-036 start held high through DONE -> second operation accepted in the done cycle; two done pulses separated by the second operation's latency.
